game_ctrl: RTL and testbench

- Top-level game sequencer for Breakout; sits between the debounced board buttons and the ball mover and block-memory datapath.
- Drives the mover's run level and a move-enable gate, counts lives, remaining blocks and score, and exposes the game state for LEDs/HUD.
- The mover's timer pulse is ANDed with move_en at integration, which allows pause without recentering the ball.

---
 rtl/game_ctrl_if.sv | 27 ++
 rtl/game_ctrl.sv | 148 ++++++++++++++
 tb/tb_game_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// Bundle between the Breakout sequencer and its neighbours: debounced buttons,
// ball-mover status/control, and the HUD-facing counters and state.
interface game_ctrl_if;
  logic        start_btn;
  logic        pause_btn;
  logic        endgame;
  logic        block_destroyed;
  logic        ball_run;
  logic        move_en;
  logic [1:0]  lives;
  logic [5:0]  blocks_left;
  logic [15:0] score;
  logic [2:0]  state;
  logic        game_over;
  logic        game_won;

  // master: the board/bench side that drives buttons and mover status
  modport master (
    output start_btn, pause_btn, endgame, block_destroyed,
    input  ball_run, move_en, lives, blocks_left, score, state, game_over, game_won
  );

  modport slave (
    input  start_btn, pause_btn, endgame, block_destroyed,
    output ball_run, move_en, lives, blocks_left, score, state, game_over, game_won
  );
endinterface

// File: rtl/game_ctrl.sv
// Breakout game sequencer: run/pause/lose/serve flow, lives, blocks and score.
// Define SCORE_BCD_EN to keep the score as four packed BCD digits instead of binary.
module game_ctrl #(
    parameter int LIVES            = 3,
    parameter int N_BLOCKS         = 40,
    parameter int POINTS_PER_BLOCK = 1,
    parameter int RESPAWN_CYCLES   = 25000000
) (
    input logic         clock,
    input logic         reset,
    game_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        PAUSE = 3'd2,
        LOSE  = 3'd3,
        SERVE = 3'd4,
        OVER  = 3'd5,
        WIN   = 3'd6
    } state_t;

    localparam int CW = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam logic [CW-1:0] RESP_LOAD   = CW'(RESPAWN_CYCLES - 1);
    localparam logic [1:0]    LIVES_INIT  = 2'(LIVES);
    localparam logic [5:0]    BLOCKS_INIT = 6'(N_BLOCKS);

    state_t        state_q, state_n;
    logic [1:0]    lives_q, lives_n;
    logic [5:0]    blocks_q, blocks_n;
    logic [15:0]   score_q, score_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          start_prev, pause_prev;
    logic          start_press, pause_press;
    logic          run_n, men_n, over_n, won_n;

    assign start_press = bus.start_btn & ~start_prev;
    assign pause_press = bus.pause_btn & ~pause_prev;

    function automatic logic [15:0] score_inc(input logic [15:0] s);
        logic [15:0] r;
`ifdef SCORE_BCD_EN
        logic [4:0] d;
        logic [4:0] add;
        r   = s;
        add = 5'(POINTS_PER_BLOCK);
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, s[4*i +: 4]} + add;
            if (d > 5'd9) begin
                r[4*i +: 4] = 4'(d - 5'd10);
                add         = 5'd1;
            end else begin
                r[4*i +: 4] = d[3:0];
                add         = 5'd0;
            end
        end
        if (add != 5'd0) r = 16'h9999;
`else
        logic [16:0] sum;
        sum = {1'b0, s} + 17'(POINTS_PER_BLOCK);
        r   = sum[16] ? 16'hFFFF : sum[15:0];
`endif
        return r;
    endfunction

    always_comb begin
        state_n  = state_q;
        lives_n  = lives_q;
        blocks_n = blocks_q;
        score_n  = score_q;
        cnt_n    = cnt_q;
        case (state_q)
            IDLE:  if (start_press) state_n = PLAY;
            PLAY: begin
                // The block is banked before any loss so a last-moment hit still scores.
                if (bus.block_destroyed && blocks_q != 6'd0) begin
                    blocks_n = blocks_q - 6'd1;
                    score_n  = score_inc(score_q);
                end
                if (bus.block_destroyed && blocks_q == 6'd1) begin
                    state_n = WIN;
                end else if (bus.endgame) begin
                    state_n = LOSE;
                    lives_n = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    cnt_n   = RESP_LOAD;
                end else if (pause_press) begin
                    state_n = PAUSE;
                end
            end
            PAUSE: if (pause_press) state_n = PLAY;
            LOSE: begin
                if (cnt_q == '0) state_n = (lives_q == 2'd0) ? OVER : SERVE;
                else             cnt_n   = cnt_q - 1'b1;
            end
            SERVE: if (start_press) state_n = PLAY;
            OVER:  if (start_press) state_n = IDLE;
            WIN:   if (start_press) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Counters are re-armed whenever the game sits in (or returns to) IDLE.
        if (state_n == IDLE) begin
            lives_n  = LIVES_INIT;
            blocks_n = BLOCKS_INIT;
            score_n  = 16'd0;
            cnt_n    = '0;
        end

        run_n  = (state_n == PLAY) || (state_n == PAUSE) || (state_n == LOSE) ||
                 (state_n == OVER) || (state_n == WIN);
        men_n  = (state_n == PLAY);
        over_n = (state_n == OVER);
        won_n  = (state_n == WIN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            lives_q       <= LIVES_INIT;
            blocks_q      <= BLOCKS_INIT;
            score_q       <= 16'd0;
            cnt_q         <= '0;
            start_prev    <= 1'b0;
            pause_prev    <= 1'b0;
            bus.ball_run  <= 1'b0;
            bus.move_en   <= 1'b0;
            bus.game_over <= 1'b0;
            bus.game_won  <= 1'b0;
        end else begin
            state_q       <= state_n;
            lives_q       <= lives_n;
            blocks_q      <= blocks_n;
            score_q       <= score_n;
            cnt_q         <= cnt_n;
            start_prev    <= bus.start_btn;
            pause_prev    <= bus.pause_btn;
            bus.ball_run  <= run_n;
            bus.move_en   <= men_n;
            bus.game_over <= over_n;
            bus.game_won  <= won_n;
        end
    end

    assign bus.state       = state_q;
    assign bus.lives       = lives_q;
    assign bus.blocks_left = blocks_q;
    assign bus.score       = score_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with LIVES=2, N_BLOCKS=3, RESPAWN_CYCLES=4, POINTS_PER_BLOCK=5.
module tb_game_ctrl;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;

    game_ctrl_if bus ();

    game_ctrl #(
        .LIVES(2),
        .N_BLOCKS(3),
        .POINTS_PER_BLOCK(5),
        .RESPAWN_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

`ifdef SCORE_BCD_EN
    localparam logic [15:0] SCORE_5  = 16'h0005;
    localparam logic [15:0] SCORE_10 = 16'h0010;
    localparam logic [15:0] SCORE_15 = 16'h0015;
`else
    localparam logic [15:0] SCORE_5  = 16'd5;
    localparam logic [15:0] SCORE_10 = 16'd10;
    localparam logic [15:0] SCORE_15 = 16'd15;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic press_start();
        bus.start_btn = 1'b1; tick(); bus.start_btn = 1'b0; tick();
    endtask

    task automatic press_pause();
        bus.pause_btn = 1'b1; tick(); bus.pause_btn = 1'b0; tick();
    endtask

    task automatic pulse_block();
        bus.block_destroyed = 1'b1; tick(); bus.block_destroyed = 1'b0;
    endtask

    task automatic pulse_endgame(input logic with_block);
        bus.endgame = 1'b1; bus.block_destroyed = with_block; tick();
        bus.endgame = 1'b0; bus.block_destroyed = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.start_btn = 1'b0; bus.pause_btn = 1'b0;
        bus.endgame = 1'b0; bus.block_destroyed = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        check("rst_state", 32'(bus.state), 0);
        check("rst_run", 32'(bus.ball_run), 0);
        check("rst_men", 32'(bus.move_en), 0);
        check("rst_lives", 32'(bus.lives), 2);
        check("rst_blocks", 32'(bus.blocks_left), 3);
        check("rst_score", 32'(bus.score), 0);

        // 1: serve from IDLE
        press_start();
        check("s1_state", 32'(bus.state), 1);
        check("s1_run", 32'(bus.ball_run), 1);
        check("s1_men", 32'(bus.move_en), 1);
        check("s1_lives", 32'(bus.lives), 2);
        check("s1_blocks", 32'(bus.blocks_left), 3);
        check("s1_score", 32'(bus.score), 0);

        // 2: clear the wall
        pulse_block();
        check("s2_blocks_a", 32'(bus.blocks_left), 2);
        check("s2_score_a", 32'(bus.score), 32'(SCORE_5));
        tick();
        pulse_block();
        check("s2_blocks_b", 32'(bus.blocks_left), 1);
        check("s2_score_b", 32'(bus.score), 32'(SCORE_10));
        pulse_block();
        check("s2_state", 32'(bus.state), 6);
        check("s2_won", 32'(bus.game_won), 1);
        check("s2_men", 32'(bus.move_en), 0);
        check("s2_blocks_c", 32'(bus.blocks_left), 0);
        check("s2_score_c", 32'(bus.score), 32'(SCORE_15));
        pulse_block();
        check("s2_blocks_sat", 32'(bus.blocks_left), 0);
        press_start();
        check("s2_idle", 32'(bus.state), 0);
        check("s2_idle_blocks", 32'(bus.blocks_left), 3);
        check("s2_idle_score", 32'(bus.score), 0);

        // 3: first miss, respawn, serve
        press_start();
        pulse_endgame(1'b0);
        check("s3_state", 32'(bus.state), 3);
        check("s3_lives", 32'(bus.lives), 1);
        check("s3_run", 32'(bus.ball_run), 1);
        check("s3_men", 32'(bus.move_en), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s3_hold_state", 32'(bus.state), 3);
            check("s3_hold_run", 32'(bus.ball_run), 1);
        end
        tick();
        check("s3_serve", 32'(bus.state), 4);
        check("s3_serve_run", 32'(bus.ball_run), 0);
        press_start();
        check("s3_play", 32'(bus.state), 1);

        // 4: last miss with a simultaneous block (counted), game over
        pulse_endgame(1'b1);
        check("s4_state", 32'(bus.state), 3);
        check("s4_lives", 32'(bus.lives), 0);
        check("s4_blocks", 32'(bus.blocks_left), 2);
        check("s4_score", 32'(bus.score), 32'(SCORE_5));
        tick(); tick(); tick();
        check("s4_hold", 32'(bus.state), 3);
        tick();
        check("s4_over", 32'(bus.state), 5);
        check("s4_over_flag", 32'(bus.game_over), 1);
        press_start();
        check("s4_idle", 32'(bus.state), 0);
        check("s4_idle_lives", 32'(bus.lives), 2);
        check("s4_idle_score", 32'(bus.score), 0);
        check("s4_idle_over", 32'(bus.game_over), 0);

        // 5: pause behaviour
        press_start();
        press_pause();
        check("s5_state", 32'(bus.state), 2);
        check("s5_men", 32'(bus.move_en), 0);
        check("s5_run", 32'(bus.ball_run), 1);
        pulse_block();
        check("s5_blocks", 32'(bus.blocks_left), 3);
        check("s5_score", 32'(bus.score), 0);
        press_start();
        check("s5_start_ign", 32'(bus.state), 2);
        press_pause();
        check("s5_resume", 32'(bus.state), 1);
        check("s5_resume_men", 32'(bus.move_en), 1);

        // 6: last block and endgame together -> WIN; then reset mid-LOSE
        pulse_block(); tick();
        pulse_block(); tick();
        check("s6_blocks", 32'(bus.blocks_left), 1);
        pulse_endgame(1'b1);
        check("s6_win", 32'(bus.state), 6);
        check("s6_lives", 32'(bus.lives), 2);
        check("s6_score", 32'(bus.score), 32'(SCORE_15));
        press_start();
        press_start();
        pulse_endgame(1'b0);
        tick();
        check("s6_lose", 32'(bus.state), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("s6_rst_state", 32'(bus.state), 0);
        check("s6_rst_run", 32'(bus.ball_run), 0);
        check("s6_rst_men", 32'(bus.move_en), 0);
        check("s6_rst_lives", 32'(bus.lives), 2);
        check("s6_rst_blocks", 32'(bus.blocks_left), 3);
        check("s6_rst_score", 32'(bus.score), 0);
        check("s6_rst_over", 32'(bus.game_over), 0);
        check("s6_rst_won", 32'(bus.game_won), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
